// File: rtl/regfile_defs.sv
// Shared register-file geometry and write-back requester indices used by the
// register-file write scheduler and its arbiter.
package regfile_defs;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_MOV  = 2;

    // Index examined k-th (k = 0 first) when the previous grant went to ptr.
    function automatic int rrSlot(input int ptr, input int k, input int n);
        return (ptr + 1 + k) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot write-port arbiter: round-robin starting after ptr_i, or fixed
// lowest-index priority when REGWR_SCHED_FIXED_PRI_EN is defined.
module rr_arbiter
    import regfile_defs::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic found;

`ifdef REGWR_SCHED_FIXED_PRI_EN
    logic unusedPtr;
    assign unusedPtr = ^ptr_i;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req_i[j]) begin
                gnt_o[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    // Walk the priority slots in order; the first asserted requester wins.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req_i[j] && (j == rrSlot(int'(ptr_i), k, NUM_REQ))) begin
                    gnt_o[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/regfile_wr_sched.sv
// Register-file write-port scheduler and pending-write scoreboard.
// Define REGWR_SCHED_FIXED_PRI_EN for fixed priority instead of round-robin.
module regfile_wr_sched #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = regfile_defs::DATA_W,
    parameter int ADDR_W  = regfile_defs::ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    input  logic [ADDR_W-1:0]         rd_addr1,
    input  logic [ADDR_W-1:0]         rd_addr2,
    output logic [2**ADDR_W-1:0]      busy,
    output logic                      hazard
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]  arbGnt;
    logic [PTR_W-1:0]    ptrArb;
    logic                xfer;
    logic [ADDR_W-1:0]   selAddr;
    logic [DATA_W-1:0]   selData;

    logic                wrEn_q,   wrEn_d;
    logic [ADDR_W-1:0]   wrAddr_q, wrAddr_d;
    logic [DATA_W-1:0]   wrData_q, wrData_d;
    logic [NUM_REGS-1:0] busy_q,   busy_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) uArb (
        .req_i (req),
        .ptr_i (ptrArb),
        .gnt_o (arbGnt)
    );

    // Grant is suppressed while reset is held so no transfer can be seen.
    assign gnt  = rst ? arbGnt : '0;
    assign xfer = |(req & gnt);

    always_comb begin
        selAddr = '0;
        selData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                selAddr = req_addr[i*ADDR_W +: ADDR_W];
                selData = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef REGWR_SCHED_FIXED_PRI_EN
    assign ptrArb = '0;
`else
    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i] && req[i]) begin
                ptr_d = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= PTR_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptrArb = ptr_q;
`endif

    // Clear lands after the file commits at the negedge; a same-edge reservation wins.
    always_comb begin
        wrEn_d   = xfer;
        wrAddr_d = xfer ? selAddr : wrAddr_q;
        wrData_d = xfer ? selData : wrData_q;
        busy_d   = busy_q;
        if (wrEn_q) begin
            busy_d[wrAddr_q] = 1'b0;
        end
        if (rsv_valid) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrEn_q   <= 1'b0;
            wrAddr_q <= '0;
            wrData_q <= '0;
            busy_q   <= '0;
        end else begin
            wrEn_q   <= wrEn_d;
            wrAddr_q <= wrAddr_d;
            wrData_q <= wrData_d;
            busy_q   <= busy_d;
        end
    end

    assign wr_en   = wrEn_q;
    assign wr_addr = wrAddr_q;
    assign wr_data = wrData_q;
    assign busy    = busy_q;
    assign hazard  = busy_q[rd_addr1] | busy_q[rd_addr2];

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Self-checking bench for regfile_wr_sched: directed scenarios then random
// traffic against a behavioural model of arbitration, register file and scoreboard.
module tb_regfile_wr_sched;
    import regfile_defs::*;

    localparam int N = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req;
    logic [N*ADDR_W-1:0]   reqAddr;
    logic [N*DATA_W-1:0]   reqData;
    logic [N-1:0]          gnt;
    logic                  wrEn;
    logic [ADDR_W-1:0]     wrAddr;
    logic [DATA_W-1:0]     wrData;
    logic                  rsvValid;
    logic [ADDR_W-1:0]     rsvAddr;
    logic [ADDR_W-1:0]     rdAddr1;
    logic [ADDR_W-1:0]     rdAddr2;
    logic [NUM_REGS-1:0]   busy;
    logic                  hazard;

    regfile_wr_sched #(.NUM_REQ(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(reqAddr), .req_data(reqData),
        .gnt(gnt), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rsv_valid(rsvValid), .rsv_addr(rsvAddr), .rd_addr1(rdAddr1),
        .rd_addr2(rdAddr2), .busy(busy), .hazard(hazard)
    );

    always #5 clk = ~clk;

    // Register file stand-in: commits at the negedge of the wr_en cycle.
    logic [DATA_W-1:0] rfDut [NUM_REGS];
    always @(negedge clk) begin
        if (wrEn === 1'b1) rfDut[wrAddr] = wrData;
    end

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0]   addrArr [N];
    logic [DATA_W-1:0]   dataArr [N];
    int                  waitCnt [N];

    int                  lastG;
    logic                mWrEn;
    logic [ADDR_W-1:0]   mWrAddr;
    logic [DATA_W-1:0]   mWrData;
    logic [NUM_REGS-1:0] mBusy;
    logic [DATA_W-1:0]   mRf [NUM_REGS];

    logic [N-1:0]        obsGnt;
    logic                obsHazard;
    logic [NUM_REGS-1:0] obsBusy;
    logic [N-1:0]        lastXfer;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] expGnt(input logic [N-1:0] r, input int last);
        logic [N-1:0] g = '0;
`ifdef REGWR_SCHED_FIXED_PRI_EN
        for (int i = N - 1; i >= 0; i--) if (r[i]) g = N'(1) << i;
`else
        for (int k = N; k >= 1; k--) if (r[(last + k) % N]) g = N'(1) << ((last + k) % N);
`endif
        return g;
    endfunction

    task automatic packReq();
        for (int i = 0; i < N; i++) begin
            reqAddr[i*ADDR_W +: ADDR_W] = addrArr[i];
            reqData[i*DATA_W +: DATA_W] = dataArr[i];
        end
    endtask

    task automatic resetModel();
        lastG   = N - 1;
        mWrEn   = 1'b0;
        mWrAddr = '0;
        mWrData = '0;
        mBusy   = '0;
        for (int i = 0; i < N; i++) waitCnt[i] = 0;
    endtask

    task automatic setReq(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req[i]     = 1'b1;
        addrArr[i] = a;
        dataArr[i] = d;
    endtask

    // One clock: check at the negedge, advance the model at the posedge, check commit just after.
    task automatic applyStimulus();
        logic [N-1:0]      eg;
        logic              oldEn;
        logic [ADDR_W-1:0] oldAddr;
        logic [DATA_W-1:0] oldData;
        packReq();
        @(negedge clk);
        eg        = expGnt(req, lastG);
        obsGnt    = gnt;
        obsHazard = hazard;
        obsBusy   = busy;
        checkOutput("gnt", 32'(gnt), 32'(eg));
        checkOutput("hazard", 32'(hazard), 32'(mBusy[rdAddr1] | mBusy[rdAddr2]));
        checkOutput("wr_en", 32'(wrEn), 32'(mWrEn));
        checkOutput("wr_addr", 32'(wrAddr), 32'(mWrAddr));
        checkOutput("wr_data", 32'(wrData), 32'(mWrData));
        checkOutput("busy", 32'(busy), 32'(mBusy));
        @(posedge clk);
        oldEn   = mWrEn;
        oldAddr = mWrAddr;
        oldData = mWrData;
        if (mWrEn) begin
            mRf[mWrAddr]   = mWrData;
            mBusy[mWrAddr] = 1'b0;
        end
        if (rsvValid) mBusy[rsvAddr] = 1'b1;
        lastXfer = req & eg;
        mWrEn    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (lastXfer[i]) begin
                mWrEn   = 1'b1;
                mWrAddr = addrArr[i];
                mWrData = dataArr[i];
                lastG   = i;
`ifndef REGWR_SCHED_FIXED_PRI_EN
                checkOutput("fair_wait", 32'(waitCnt[i] <= N - 1), 32'd1);
`endif
                waitCnt[i] = 0;
            end else if (req[i]) begin
                waitCnt[i]++;
            end else begin
                waitCnt[i] = 0;
            end
        end
        #1;
        if (oldEn) checkOutput("rf_commit", 32'(rfDut[oldAddr]), 32'(oldData));
    endtask

    initial begin
        logic [N-1:0] heldSeen;
        int           heldCycles;

        for (int r = 0; r < NUM_REGS; r++) begin
            rfDut[r] = '0;
            mRf[r]   = '0;
        end
        rst      = 1'b0;
        req      = '1;
        rsvValid = 1'b0;
        rsvAddr  = '0;
        rdAddr1  = '0;
        rdAddr2  = '0;
        for (int i = 0; i < N; i++) begin
            addrArr[i] = ADDR_W'(i + 1);
            dataArr[i] = DATA_W'(8'h10 + i);
        end
        packReq();
        resetModel();

        $display("[TB] reset with all requests asserted");
        #3;
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_wr_en", 32'(wrEn), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        checkOutput("rst_gnt_edge", 32'(gnt), 32'd0);
        checkOutput("rst_wr_en_edge", 32'(wrEn), 32'd0);
        rst = 1'b1;

        $display("[TB] rotation with all requesters held");
        for (int c = 0; c < 6; c++) begin
            applyStimulus();
`ifdef REGWR_SCHED_FIXED_PRI_EN
            checkOutput("rot_order", 32'(obsGnt), 32'd1);
`else
            checkOutput("rot_order", 32'(obsGnt), 32'(1 << (c % N)));
`endif
            for (int i = 0; i < N; i++) begin
                if (lastXfer[i]) begin
                    addrArr[i] = ADDR_W'(c);
                    dataArr[i] = DATA_W'(8'h20 + c * 8'h11);
                    if (c >= 3) req[i] = 1'b0;
                end
            end
        end
`ifdef REGWR_SCHED_FIXED_PRI_EN
        req = '0;
`endif
        applyStimulus();
        req = '0;
        applyStimulus();

        $display("[TB] single request from the load port");
        setReq(REQ_LOAD, 3'd5, 8'hA7);
        applyStimulus();
        checkOutput("single_gnt", 32'(obsGnt), 32'b010);
        req = '0;
        applyStimulus();
        applyStimulus();
        checkOutput("single_rf_r5", 32'(rfDut[5]), 32'hA7);

        $display("[TB] scoreboard reserve and clear of R3");
        rsvValid = 1'b1;
        rsvAddr  = 3'd3;
        applyStimulus();
        rsvValid = 1'b0;
        rdAddr1  = 3'd3;
        rdAddr2  = 3'd0;
        setReq(REQ_ALU, 3'd3, 8'h33);
        applyStimulus();
        checkOutput("sb_hazard_set", 32'(obsHazard), 32'd1);
        req = '0;
        applyStimulus();
        checkOutput("sb_hazard_wr_cycle", 32'(obsHazard), 32'd1);
        applyStimulus();
        checkOutput("sb_hazard_cleared", 32'(obsHazard), 32'd0);

        $display("[TB] set and clear collision on R2");
        rsvValid = 1'b1;
        rsvAddr  = 3'd2;
        setReq(REQ_ALU, 3'd2, 8'hE2);
        applyStimulus();
        req = '0;
        applyStimulus();
        rsvValid = 1'b0;
        applyStimulus();
        checkOutput("collision_busy2", 32'(obsBusy[2]), 32'd1);

        $display("[TB] held request under competing traffic");
        setReq(REQ_MOV, 3'd6, 8'h66);
        applyStimulus();
        req = '0;
        applyStimulus();
        setReq(REQ_MOV, 3'd7, 8'hC7);
        heldSeen   = '0;
        heldCycles = 0;
        for (int c = 0; c < 4 && !heldSeen[REQ_MOV]; c++) begin
            setReq(REQ_ALU, 3'd1, DATA_W'($urandom));
            applyStimulus();
            heldCycles++;
            heldSeen = heldSeen | obsGnt;
            if (lastXfer[REQ_MOV]) req[REQ_MOV] = 1'b0;
        end
`ifndef REGWR_SCHED_FIXED_PRI_EN
        checkOutput("held_granted_in_2", 32'(heldSeen[REQ_MOV] && heldCycles <= 2), 32'd1);
`endif
        req = '0;
        applyStimulus();
        applyStimulus();

        $display("[TB] reset in the middle of a write");
        setReq(REQ_ALU, 3'd4, 8'h5C);
        applyStimulus();
        req = '0;
        rst = 1'b0;
        #1;
        checkOutput("midrst_wr_en", 32'(wrEn), 32'd0);
        checkOutput("midrst_wr_addr", 32'(wrAddr), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk); #1;
        checkOutput("midrst_no_write", 32'(rfDut[4]), 32'(mRf[4]));
        resetModel();
        @(posedge clk); #1;
        rst = 1'b1;

        $display("[TB] random traffic");
        req = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] || lastXfer[i]) begin
                    req[i]     = 1'($urandom_range(0, 1));
                    addrArr[i] = ADDR_W'($urandom_range(0, NUM_REGS - 1));
                    dataArr[i] = DATA_W'($urandom);
                end
            end
            rsvValid = ($urandom_range(0, 3) == 0);
            rsvAddr  = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            rdAddr1  = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            rdAddr2  = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            lastXfer = '0;
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
